// File: rtl/tpmem_col_serializer.sv
// Column-vector FIFO for the transpose-memory output, drained one coefficient
// per cycle under valid/ready with regenerated element/column/block markers.
module tpmem_col_serializer #(
    parameter int BW    = 11,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              i_clk,
    input  logic              i_Reset,
    input  logic [16*BW-1:0]  i_data,
    input  logic              i_en,
    input  logic              i_ready,
    output logic [BW-1:0]     o_data,
    output logic              o_valid,
    output logic [3:0]        o_elem_idx,
    output logic [3:0]        o_col_idx,
    output logic              o_last,
    output logic              o_blk_last,
    output logic              o_overflow,
    output logic [AW:0]       o_level
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [16*BW-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q, level_d;
    logic [3:0]       elem_q, elem_d, col_q, col_d;
    logic             overflow_q, overflow_d;

    logic [BW-1:0]    data_q, data_d;
    logic             valid_q, valid_d;
    logic [3:0]       oelem_q, oelem_d, ocol_q, ocol_d;
    logic             last_q, last_d, blk_last_q, blk_last_d;

    logic [16*BW-1:0] head;
    logic [BW-1:0]    elem_arr [16];
    logic             empty, full, load, pop, wr_ok;

    // Head vector is read asynchronously so element 0 can load the cycle after a write.
    assign head = mem_q[rd_ptr_q];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_elem
            assign elem_arr[gi] = head[(16-gi)*BW-1 -: BW];
        end
    endgenerate

    assign empty = (level_q == '0);
    assign full  = (level_q == FULL_LVL);
    assign load  = (!valid_q || i_ready) && !empty;
    assign pop   = load && (elem_q == 4'd15);
    assign wr_ok = i_en && (!full || pop);

    always_comb begin
        level_d    = level_q;
        elem_d     = elem_q;
        col_d      = col_q;
        overflow_d = overflow_q | (i_en & ~wr_ok);
        data_d     = data_q;
        valid_d    = valid_q;
        oelem_d    = oelem_q;
        ocol_d     = ocol_q;
        last_d     = last_q;
        blk_last_d = blk_last_q;

        case ({wr_ok, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (load) begin
            data_d     = elem_arr[elem_q];
            valid_d    = 1'b1;
            oelem_d    = elem_q;
            ocol_d     = col_q;
            last_d     = (elem_q == 4'd15);
            blk_last_d = (elem_q == 4'd15) && (col_q == 4'd15);
            elem_d     = elem_q + 4'd1;
            if (pop) begin
                col_d = col_q + 4'd1;
            end
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            elem_q     <= '0;
            col_q      <= '0;
            overflow_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            oelem_q    <= '0;
            ocol_q     <= '0;
            last_q     <= 1'b0;
            blk_last_q <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q    <= level_d;
            elem_q     <= elem_d;
            col_q      <= col_d;
            overflow_q <= overflow_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            oelem_q    <= oelem_d;
            ocol_q     <= ocol_d;
            last_q     <= last_d;
            blk_last_q <= blk_last_d;
        end
    end

    // Storage has no reset so it maps onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (wr_ok && !i_Reset) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_elem_idx = oelem_q;
    assign o_col_idx  = ocol_q;
    assign o_last     = last_q;
    assign o_blk_last = blk_last_q;
    assign o_overflow = overflow_q;
    assign o_level    = level_q;

endmodule
